// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage and IF/ID pipeline register: PC, instruction-memory handshake, skid and drain handling.
// Optional performance counters are enabled by defining IF_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   output logic [31:0] o_imem_addr,
   output logic        o_imem_read,
   input  logic [31:0] i_imem_readdata,
   input  logic        i_imem_busywait,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc_plus4,
   output logic [31:0] o_if_id_instr,
   output logic        o_if_id_valid,
`ifdef IF_PERF_COUNTERS_EN
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_busy_cycles,
`endif
   output logic        o_fetch_stall
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_drain_addr;
   logic [31:0] w_drain_addr_nxt;
   logic [31:0] r_skid;
   logic [31:0] w_skid_nxt;
   logic [31:0] r_if_id_pc;
   logic [31:0] w_if_id_pc_nxt;
   logic [31:0] r_if_id_pc_plus4;
   logic [31:0] w_if_id_pc_plus4_nxt;
   logic [31:0] r_if_id_instr;
   logic [31:0] w_if_id_instr_nxt;
   logic        r_if_id_valid;
   logic        w_if_id_valid_nxt;
   logic        w_load_valid;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;
   logic        w_accept;

   assign w_target   = {i_branch_target[31:2], 2'b00};
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_accept   = ~i_imem_busywait;

   // Request is suppressed while reset is held so nothing is issued before release.
   assign o_imem_read      = i_reset & (r_state != ST_HOLD);
   assign o_imem_addr      = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
   assign o_fetch_stall    = o_imem_read & i_imem_busywait;
   assign o_if_id_pc       = r_if_id_pc;
   assign o_if_id_pc_plus4 = r_if_id_pc_plus4;
   assign o_if_id_instr    = r_if_id_instr;
   assign o_if_id_valid    = r_if_id_valid;

   always_comb begin
      w_state_nxt          = r_state;
      w_pc_nxt             = r_pc;
      w_drain_addr_nxt     = r_drain_addr;
      w_skid_nxt           = r_skid;
      w_if_id_pc_nxt       = r_if_id_pc;
      w_if_id_pc_plus4_nxt = r_if_id_pc_plus4;
      w_if_id_instr_nxt    = r_if_id_instr;
      w_if_id_valid_nxt    = r_if_id_valid;
      w_load_valid         = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (w_accept && i_branch_taken) begin
               w_pc_nxt          = w_target;
               w_if_id_instr_nxt = NOP_INSTR;
               w_if_id_valid_nxt = 1'b0;
            end else if (i_branch_taken) begin
               // The in-flight request must complete at its original address before redirecting.
               w_drain_addr_nxt  = r_pc;
               w_pc_nxt          = w_target;
               w_if_id_instr_nxt = NOP_INSTR;
               w_if_id_valid_nxt = 1'b0;
               w_state_nxt       = ST_DRAIN;
            end else if (w_accept && !i_stall) begin
               w_if_id_pc_nxt       = r_pc;
               w_if_id_pc_plus4_nxt = w_pc_plus4;
               w_if_id_instr_nxt    = i_imem_readdata;
               w_if_id_valid_nxt    = 1'b1;
               w_load_valid         = 1'b1;
               w_pc_nxt             = w_pc_plus4;
            end else if (w_accept) begin
               w_skid_nxt  = i_imem_readdata;
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (i_branch_taken) begin
               w_pc_nxt          = w_target;
               w_if_id_instr_nxt = NOP_INSTR;
               w_if_id_valid_nxt = 1'b0;
               w_state_nxt       = ST_FETCH;
            end else if (!i_stall) begin
               w_if_id_pc_nxt       = r_pc;
               w_if_id_pc_plus4_nxt = w_pc_plus4;
               w_if_id_instr_nxt    = r_skid;
               w_if_id_valid_nxt    = 1'b1;
               w_load_valid         = 1'b1;
               w_pc_nxt             = w_pc_plus4;
               w_state_nxt          = ST_FETCH;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
            if (i_branch_taken) begin
               w_pc_nxt = w_target;
            end else begin
               w_pc_nxt = r_pc;
            end
            if (w_accept) begin
               w_state_nxt = ST_FETCH;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state          <= ST_FETCH;
         r_pc             <= RESET_PC;
         r_drain_addr     <= 32'd0;
         r_skid           <= 32'd0;
         r_if_id_pc       <= 32'd0;
         r_if_id_pc_plus4 <= 32'd0;
         r_if_id_instr    <= NOP_INSTR;
         r_if_id_valid    <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_pc             <= w_pc_nxt;
         r_drain_addr     <= w_drain_addr_nxt;
         r_skid           <= w_skid_nxt;
         r_if_id_pc       <= w_if_id_pc_nxt;
         r_if_id_pc_plus4 <= w_if_id_pc_plus4_nxt;
         r_if_id_instr    <= w_if_id_instr_nxt;
         r_if_id_valid    <= w_if_id_valid_nxt;
      end
   end

`ifdef IF_PERF_COUNTERS_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_busy_cycles;

   assign o_perf_fetched     = r_perf_fetched;
   assign o_perf_busy_cycles = r_perf_busy_cycles;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_perf_fetched     <= 32'd0;
         r_perf_busy_cycles <= 32'd0;
      end else begin
         r_perf_fetched     <= r_perf_fetched + {31'd0, w_load_valid};
         r_perf_busy_cycles <= r_perf_busy_cycles + {31'd0, o_fetch_stall};
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit: streaming, wait states, stall skid, redirects.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic        imem_read;
   logic [31:0] imem_readdata;
   logic        imem_busywait;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fetch_stall;
`ifdef IF_PERF_COUNTERS_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_busy_cycles;
`endif

   int checks;
   int failures;

   instruction_fetch_unit dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_stall          (stall),
      .i_branch_taken   (branch_taken),
      .i_branch_target  (branch_target),
      .o_imem_addr      (imem_addr),
      .o_imem_read      (imem_read),
      .i_imem_readdata  (imem_readdata),
      .i_imem_busywait  (imem_busywait),
      .o_if_id_pc       (if_id_pc),
      .o_if_id_pc_plus4 (if_id_pc_plus4),
      .o_if_id_instr    (if_id_instr),
      .o_if_id_valid    (if_id_valid),
`ifdef IF_PERF_COUNTERS_EN
      .o_perf_fetched     (perf_fetched),
      .o_perf_busy_cycles (perf_busy_cycles),
`endif
      .o_fetch_stall    (fetch_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        branch;
      logic [31:0] target;
      logic        busy;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic        e_read;
      logic        e_fs;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
      logic [31:0] e_instr;
      logic        e_valid;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
      imem_readdata = 32'd0;
      imem_busywait = 1'b0;

      //                stl   br    target         busy  rdata           addr           rd    fs    pc             pc4            instr          v
      vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00500093, 32'h0,         1'b1, 1'b0, 32'h0,         32'h4,         32'h00500093, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00A00113, 32'h4,         1'b1, 1'b0, 32'h4,         32'h8,         32'h00A00113, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 32'h8,         1'b1, 1'b1, 32'h4,         32'h8,         32'h00A00113, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 32'h8,         1'b1, 1'b1, 32'h4,         32'h8,         32'h00A00113, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 32'h8,         1'b1, 1'b1, 32'h4,         32'h8,         32'h00A00113, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h002081B3, 32'h8,         1'b1, 1'b0, 32'h8,         32'hC,         32'h002081B3, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h00308233, 32'hC,         1'b1, 1'b0, 32'h8,         32'hC,         32'h002081B3, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 32'hC,         1'b0, 1'b0, 32'h8,         32'hC,         32'h002081B3, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF, 32'hC,         1'b0, 1'b0, 32'hC,         32'h10,        32'h00308233, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 32'h100,       1'b1, 32'hDEADBEEF, 32'h10,        1'b1, 1'b1, 32'hC,         32'h10,        32'h00000013, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF, 32'h10,        1'b1, 1'b1, 32'hC,         32'h10,        32'h00000013, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hBADC0DE3, 32'h10,        1'b1, 1'b0, 32'hC,         32'h10,        32'h00000013, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00000073, 32'h100,       1'b1, 1'b0, 32'h100,       32'h104,       32'h00000073, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 32'hFFFFFFFF,  1'b0, 32'h11111111, 32'h104,       1'b1, 1'b0, 32'h100,       32'h104,       32'h00000013, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h22222293, 32'hFFFFFFFC,  1'b1, 1'b0, 32'h100,       32'h104,       32'h00000013, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF, 32'hFFFFFFFC,  1'b0, 1'b0, 32'hFFFFFFFC,  32'h0,         32'h22222293, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00100093, 32'h0,         1'b1, 1'b0, 32'h0,         32'h4,         32'h00100093, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 32'h200,       1'b1, 32'hDEADBEEF, 32'h4,         1'b1, 1'b1, 32'h0,         32'h4,         32'h00000013, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 32'h300,       1'b1, 32'hDEADBEEF, 32'h4,         1'b1, 1'b1, 32'h0,         32'h4,         32'h00000013, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hDEADBEEF, 32'h4,         1'b1, 1'b0, 32'h0,         32'h4,         32'h00000013, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00200113, 32'h300,       1'b1, 1'b0, 32'h300,       32'h304,       32'h00200113, 1'b1};
      vecs[21] = '{1'b0, 1'b1, 32'h40,        1'b0, 32'h33333333, 32'h304,       1'b1, 1'b0, 32'h300,       32'h304,       32'h00000013, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h00300193, 32'h40,        1'b1, 1'b0, 32'h40,        32'h44,        32'h00300193, 1'b1};

      // Reset held for two edges.
      @(negedge clk);
      check("reset_read", {31'd0, imem_read}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_valid", {31'd0, if_id_valid}, 32'd0);
      check("reset_instr", if_id_instr, 32'h00000013);
      check("reset_pc", if_id_pc, 32'd0);
      check("reset_pc4", if_id_pc_plus4, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         stall         = vecs[i].stall;
         branch_taken  = vecs[i].branch;
         branch_target = vecs[i].target;
         imem_busywait = vecs[i].busy;
         imem_readdata = vecs[i].rdata;
         @(negedge clk);
         check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         check($sformatf("v%0d_read", i), {31'd0, imem_read}, {31'd0, vecs[i].e_read});
         check($sformatf("v%0d_fstall", i), {31'd0, fetch_stall}, {31'd0, vecs[i].e_fs});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pc", i), if_id_pc, vecs[i].e_pc);
         check($sformatf("v%0d_pc4", i), if_id_pc_plus4, vecs[i].e_pc4);
         check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
         check($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      end

      // Reset asserted mid-transfer while memory is busy: request must drop immediately.
      stall         = 1'b0;
      branch_taken  = 1'b0;
      imem_busywait = 1'b1;
      reset         = 1'b0;
      @(negedge clk);
      check("midreset_read", {31'd0, imem_read}, 32'd0);
      check("midreset_fstall", {31'd0, fetch_stall}, 32'd0);
      @(posedge clk);
      #1;
      check("midreset_valid", {31'd0, if_id_valid}, 32'd0);
      check("midreset_instr", if_id_instr, 32'h00000013);
      check("midreset_pc", if_id_pc, 32'd0);
      reset         = 1'b1;
      imem_busywait = 1'b0;
      imem_readdata = 32'h00400213;
      @(negedge clk);
      check("postreset_addr", imem_addr, 32'd0);
      check("postreset_read", {31'd0, imem_read}, 32'd1);
      @(posedge clk);
      #1;
      check("postreset_instr", if_id_instr, 32'h00400213);
      check("postreset_valid", {31'd0, if_id_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
